// File: rtl/song_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg
// Shared definitions for the song sequencer: where each field sits in a
// 16-bit song ROM word, the note number used for a rest, and the sequencer
// FSM state type.
// ---------------------------------------------------------------------------
package song_pkg;

    // ROM word layout: [15] chord flag, [14:9] note, [8:3] duration,
    // [2:0] reserved and ignored by the sequencer.
    localparam int CHORD_BIT = 15;
    localparam int NOTE_MSB  = 14;
    localparam int NOTE_LSB  = 9;
    localparam int DUR_MSB   = 8;
    localparam int DUR_LSB   = 3;

    // Note number that means silence.
    localparam int REST_NOTE = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_PLAY,
        ST_ADVANCE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/beat_counter.sv
// ---------------------------------------------------------------------------
// beat_counter
// Counts beat ticks while a note is sounding. terminal is high when the count
// has reached limit-1, so the beat that arrives while terminal is high is the
// last beat of the note. Because the count only climbs to limit-1 before the
// note ends, a limit of 2^DUR_W-1 never wraps the counter.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   clear    synchronous clear, wins over enable
//   enable   count one beat this cycle
//   limit    note duration in beats
//   terminal count == limit-1
// ---------------------------------------------------------------------------
module beat_counter #(
    parameter int DUR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DUR_W-1:0] limit,
    output logic             terminal
);

    logic [DUR_W-1:0] count;

    // Clear takes priority so that a restart arriving on the same cycle as a
    // beat leaves the counter at zero rather than one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + DUR_W'(1);
        end
    end

    // The comparison looks at the current count, so the terminal beat is
    // recognised in the cycle it arrives.
    assign terminal = (count == limit - DUR_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
// Walks the song ROM one entry at a time, decodes each entry into a note and a
// duration in beats, hands each note to the note player with a one-cycle
// strobe, and times the note by counting beat ticks. It is the only master of
// the ROM address bus.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   play       level, 1 = run, 0 = pause
//   restart    one-cycle pulse, abort the current note and start at address 0
//   beat       one-cycle beat tick from the tempo divider
//   rom_addr   song ROM read address (registered)
//   rom_data   ROM word returned one cycle after rom_addr changes
//   note       current note number (0 = rest)
//   duration   current note duration in beats
//   new_note   one-cycle strobe, note/duration valid in the same cycle
//   playing    high in every state except IDLE and DONE
//   song_done  one-cycle strobe at end of song
// ---------------------------------------------------------------------------
module song_sequencer
    import song_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter bit LOOP   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              restart,
    input  logic              beat,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              playing,
    output logic              song_done
);

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    logic              entry_chord;
    logic [NOTE_W-1:0] entry_note;
    logic [DUR_W-1:0]  entry_dur;
    logic              unused_rsvd;

    logic              cnt_clear;
    logic              cnt_enable;
    logic              cnt_terminal;
    logic              last_beat;

    // Field extraction from the ROM word. The reserved bits are folded into a
    // dummy signal so they are visibly consumed and deliberately ignored.
    assign entry_chord = rom_data[CHORD_BIT];
    assign entry_note  = NOTE_W'(rom_data[NOTE_MSB:NOTE_LSB]);
    assign entry_dur   = DUR_W'(rom_data[DUR_MSB:DUR_LSB]);
    assign unused_rsvd = ^rom_data[DUR_LSB-1:0];

    // The counter restarts at every decode so each note times from zero, and
    // a restart wipes it regardless of state. Beats only count in PLAY while
    // running; a paused sequencer ignores them.
    assign cnt_clear  = restart || (state == ST_DECODE);
    assign cnt_enable = (state == ST_PLAY) && play && beat;
    assign last_beat  = cnt_enable && cnt_terminal;

    beat_counter #(
        .DUR_W (DUR_W)
    ) u_beat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .limit    (duration),
        .terminal (cnt_terminal)
    );

    // Sequencer FSM with registered outputs. Restart is checked before the
    // state case so it beats both a coincident beat and a note expiring.
    // FETCH and WAIT ignore play so an issued ROM read always lands; the
    // pause then takes hold in DECODE, which waits for play before decoding
    // exactly once. playing is written alongside every state change so it
    // always reflects the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            rom_addr  <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
            playing   <= 1'b0;
        end else begin
            new_note  <= 1'b0;
            song_done <= 1'b0;
            if (restart) begin
                ptr     <= '0;
                note    <= NOTE_W'(REST_NOTE);
                state   <= play ? ST_FETCH : ST_IDLE;
                playing <= play;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (play) begin
                            state   <= ST_FETCH;
                            playing <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        rom_addr <= ptr;
                        state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        state <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        if (play) begin
                            if (entry_dur == '0) begin
                                song_done <= 1'b1;
                                if (LOOP) begin
                                    ptr   <= '0;
                                    state <= ST_FETCH;
                                end else begin
                                    note    <= NOTE_W'(REST_NOTE);
                                    state   <= ST_DONE;
                                    playing <= 1'b0;
                                end
                            end else begin
                                note     <= entry_note;
                                duration <= entry_dur;
                                new_note <= 1'b1;
                                state    <= entry_chord ? ST_ADVANCE : ST_PLAY;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (last_beat) begin
                            state <= ST_ADVANCE;
                        end
                    end
                    ST_ADVANCE: begin
                        if (play) begin
                            ptr <= ptr + ADDR_W'(1);
                            if (ptr == {ADDR_W{1'b1}}) begin
                                song_done <= 1'b1;
                                if (LOOP) begin
                                    state <= ST_FETCH;
                                end else begin
                                    note    <= NOTE_W'(REST_NOTE);
                                    state   <= ST_DONE;
                                    playing <= 1'b0;
                                end
                            end else begin
                                state <= ST_FETCH;
                            end
                        end
                    end
                    ST_DONE: begin
                        note <= NOTE_W'(REST_NOTE);
                    end
                    default: begin
                        state   <= ST_IDLE;
                        playing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// ---------------------------------------------------------------------------
// tb_song_sequencer
// Self-checking bench for song_sequencer. A song ROM with a one-cycle
// registered read is modelled here, beats arrive every fourth cycle, and a
// note-level model predicts every output on every cycle. Directed scenarios
// add literal expectations on strobe timing, note values and beat counts.
// ---------------------------------------------------------------------------
module tb_song_sequencer;

    logic        clk;
    logic        rst_n;
    logic        play;
    logic        restart;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        new_note;
    logic        playing;
    logic        song_done;

    logic [15:0] mem [128];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;
    int phase    = 0;

    int strobe_cyc[$];
    int strobe_note[$];
    int strobe_dur[$];
    int beat_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;

    typedef enum int {M_IDLE, M_GAP, M_BEATS, M_DONE} mmode_t;
    mmode_t m_mode;
    int     m_gap;
    int     m_remain;
    int     m_ptr;
    int     m_addr;
    int     m_note;
    int     m_dur;
    int     m_nn;
    int     m_sd;

    song_sequencer #(
        .ADDR_W (7),
        .NOTE_W (6),
        .DUR_W  (6),
        .LOOP   (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play      (play),
        .restart   (restart),
        .beat      (beat),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .playing   (playing),
        .song_done (song_done)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Song ROM with a single-cycle synchronous read.
    always @(posedge clk) rom_data <= mem[rom_addr];

    // Beat tick every fourth cycle, changed just after the falling edge.
    initial begin
        beat = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            beat = (phase % 4 == 0);
            phase++;
        end
    end

    function automatic logic [15:0] entry(input bit chord, input int n, input int d);
        logic [5:0] nf;
        logic [5:0] df;
        nf = 6'(n);
        df = 6'(d);
        return {chord, nf, df, 3'b000};
    endfunction

    function automatic int beatsBetween(input int a, input int b);
        int c = 0;
        foreach (beat_cyc[i]) if (beat_cyc[i] > a && beat_cyc[i] <= b) c++;
        return c;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc_no);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic r);
        @(negedge clk);
        #2;
        play    = p;
        restart = r;
    endtask

    // Note-level model: the time to the next note is a countdown of edges
    // (4 = advancing the pointer, 3 = issuing the read, 2 = read in flight,
    // 1 = decoding); a sounding note is a count of beats still owed. Pause
    // only holds the steps that do not have a ROM read in flight.
    task automatic modelReset();
        m_mode   = M_IDLE;
        m_gap    = 0;
        m_remain = 0;
        m_ptr    = 0;
        m_addr   = 0;
        m_note   = 0;
        m_dur    = 0;
        m_nn     = 0;
        m_sd     = 0;
    endtask

    task automatic modelDecode();
        logic [15:0] w;
        int d;
        w = mem[m_ptr];
        d = int'(w[8:3]);
        if (d == 0) begin
            m_sd   = 1;
            m_note = 0;
            m_mode = M_DONE;
        end else begin
            m_note = int'(w[14:9]);
            m_dur  = d;
            m_nn   = 1;
            if (w[15]) begin
                m_gap = 4;
            end else begin
                m_mode   = M_BEATS;
                m_remain = d;
            end
        end
    endtask

    task automatic modelStep();
        m_nn = 0;
        m_sd = 0;
        if (restart) begin
            m_ptr    = 0;
            m_note   = 0;
            m_remain = 0;
            if (play) begin
                m_mode = M_GAP;
                m_gap  = 3;
            end else begin
                m_mode = M_IDLE;
            end
        end else begin
            case (m_mode)
                M_IDLE: if (play) begin
                    m_mode = M_GAP;
                    m_gap  = 3;
                end
                M_GAP: begin
                    if (m_gap == 1) begin
                        if (play) modelDecode();
                    end else if (m_gap == 4) begin
                        if (play) begin
                            if (m_ptr == 127) begin
                                m_sd   = 1;
                                m_ptr  = 0;
                                m_note = 0;
                                m_mode = M_DONE;
                            end else begin
                                m_ptr++;
                                m_gap = 3;
                            end
                        end
                    end else begin
                        if (m_gap == 3) m_addr = m_ptr;
                        m_gap--;
                    end
                end
                M_BEATS: if (play && beat) begin
                    m_remain--;
                    if (m_remain == 0) begin
                        m_mode = M_GAP;
                        m_gap  = 4;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compareModel();
        checkOutput("rom_addr", int'(rom_addr), m_addr);
        checkOutput("note", int'(note), m_note);
        checkOutput("duration", int'(duration), m_dur);
        checkOutput("new_note", int'(new_note), m_nn);
        checkOutput("song_done", int'(song_done), m_sd);
        checkOutput("playing", int'(playing), (m_mode == M_GAP || m_mode == M_BEATS) ? 1 : 0);
    endtask

    // Compare process: on each falling edge advance the model by the rising
    // edge just taken, check every output, then log strobes and beats.
    initial begin
        modelReset();
        forever begin
            @(negedge clk);
            if (!rst_n) modelReset();
            else modelStep();
            compareModel();
            if (rst_n && new_note) begin
                strobe_cyc.push_back(cyc_no);
                strobe_note.push_back(int'(note));
                strobe_dur.push_back(int'(duration));
            end
            if (rst_n && play && beat) beat_cyc.push_back(cyc_no);
            if (rst_n && song_done) begin
                done_cnt++;
                done_cyc = cyc_no;
            end
            cyc_no++;
        end
    end

    task automatic clearLog();
        strobe_cyc.delete();
        strobe_note.delete();
        strobe_dur.delete();
        done_cnt = 0;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    endtask

    task automatic waitStrobes(input int n, input int budget);
        for (int i = 0; i < budget && strobe_cyc.size() < n; i++) applyStimulus(1'b1, 1'b0);
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget && done_cnt < 1; i++) applyStimulus(1'b1, 1'b0);
    endtask

    task automatic pulseRestart();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
    endtask

    // Directed scenarios.
    initial begin
        int start_cyc;
        int resume_cyc;
        int n_before;
        int saw41;
        int fired;

        rst_n   = 1'b0;
        play    = 1'b0;
        restart = 1'b0;
        clearMem();

        // Two plain notes from power-up.
        mem[0] = entry(0, 49, 12);
        mem[1] = entry(0, 1, 8);
        repeat (3) applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);
        clearLog();
        applyStimulus(1'b1, 1'b0);
        start_cyc = cyc_no;
        waitStrobes(2, 200);
        checkOutput("t1_strobe_count", strobe_cyc.size(), 2);
        if (strobe_cyc.size() >= 2) begin
            checkOutput("t1_latency", strobe_cyc[0] - start_cyc, 3);
            checkOutput("t1_note0", strobe_note[0], 49);
            checkOutput("t1_dur0", strobe_dur[0], 12);
            checkOutput("t1_note1", strobe_note[1], 1);
            checkOutput("t1_dur1", strobe_dur[1], 8);
            checkOutput("t1_beats", beatsBetween(strobe_cyc[0], strobe_cyc[1] - 4), 12);
        end

        // Asynchronous reset in the middle of a note, between clock edges.
        repeat (10) applyStimulus(1'b1, 1'b0);
        checkOutput("t2_playing_before", int'(playing), 1);
        checkOutput("t2_note_before", int'(note), 1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t2_rom_addr", int'(rom_addr), 0);
        checkOutput("t2_note", int'(note), 0);
        checkOutput("t2_duration", int'(duration), 0);
        checkOutput("t2_new_note", int'(new_note), 0);
        checkOutput("t2_song_done", int'(song_done), 0);
        checkOutput("t2_playing", int'(playing), 0);
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;

        // Chord pair: second strobe four cycles later, no beat consumed.
        clearMem();
        mem[0] = entry(1, 49, 5);
        mem[1] = entry(0, 7, 2);
        applyStimulus(1'b0, 1'b0);
        clearLog();
        applyStimulus(1'b1, 1'b0);
        waitStrobes(2, 100);
        waitDone(100);
        checkOutput("t3_strobe_count", strobe_cyc.size(), 2);
        checkOutput("t3_done_count", done_cnt, 1);
        if (strobe_cyc.size() >= 2) begin
            checkOutput("t3_gap", strobe_cyc[1] - strobe_cyc[0], 4);
            checkOutput("t3_note0", strobe_note[0], 49);
            checkOutput("t3_note1", strobe_note[1], 7);
            checkOutput("t3_beats", beatsBetween(strobe_cyc[1], done_cyc - 4), 2);
        end

        // Longest legal duration.
        clearMem();
        mem[0] = entry(0, 5, 63);
        mem[1] = entry(0, 6, 1);
        clearLog();
        pulseRestart();
        waitStrobes(2, 400);
        checkOutput("t7_strobe_count", strobe_cyc.size(), 2);
        if (strobe_cyc.size() >= 2) begin
            checkOutput("t7_dur0", strobe_dur[0], 63);
            checkOutput("t7_beats", beatsBetween(strobe_cyc[0], strobe_cyc[1] - 4), 63);
            checkOutput("t7_note1", strobe_note[1], 6);
        end
        waitDone(100);

        // Pause for 20 beats after 5 beats of a 12-beat note.
        clearMem();
        mem[0] = entry(0, 33, 12);
        mem[1] = entry(0, 2, 4);
        clearLog();
        pulseRestart();
        waitStrobes(1, 50);
        checkOutput("t5_first_strobe", strobe_cyc.size(), 1);
        if (strobe_cyc.size() >= 1) begin
            for (int i = 0; i < 60 && beatsBetween(strobe_cyc[0], cyc_no - 1) < 5; i++)
                applyStimulus(1'b1, 1'b0);
            checkOutput("t5_beats_before_pause", beatsBetween(strobe_cyc[0], cyc_no - 1), 5);
            repeat (80) applyStimulus(1'b0, 1'b0);
            checkOutput("t5_paused_playing", int'(playing), 1);
            checkOutput("t5_paused_note", int'(note), 33);
            checkOutput("t5_no_strobe_in_pause", strobe_cyc.size(), 1);
            applyStimulus(1'b1, 1'b0);
            resume_cyc = cyc_no;
            waitStrobes(2, 100);
            checkOutput("t5_strobe_count", strobe_cyc.size(), 2);
            if (strobe_cyc.size() >= 2) begin
                checkOutput("t5_beats_after", beatsBetween(resume_cyc - 1, strobe_cyc[1] - 4), 7);
                checkOutput("t5_beats_total", beatsBetween(strobe_cyc[0], strobe_cyc[1] - 4), 12);
                checkOutput("t5_note1", strobe_note[1], 2);
            end
        end
        waitDone(100);

        // End-of-song marker at address 28.
        clearMem();
        for (int i = 0; i < 28; i++) mem[i] = entry(1, i + 1, 1);
        clearLog();
        pulseRestart();
        waitDone(300);
        checkOutput("t4_done_count", done_cnt, 1);
        checkOutput("t4_strobes", strobe_cyc.size(), 28);
        if (strobe_cyc.size() >= 1)
            checkOutput("t4_done_delay", done_cyc - strobe_cyc[strobe_cyc.size() - 1], 4);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t4_playing", int'(playing), 0);
        checkOutput("t4_note", int'(note), 0);
        repeat (40) applyStimulus(1'b1, 1'b0);
        checkOutput("t4_still_strobes", strobe_cyc.size(), 28);
        checkOutput("t4_still_done", done_cnt, 1);

        // Restart on the last beat of the note at address 40.
        clearMem();
        for (int i = 0; i < 40; i++) mem[i] = entry(1, i + 1, 1);
        mem[40] = entry(0, 50, 3);
        mem[41] = entry(0, 51, 3);
        clearLog();
        pulseRestart();
        fired = 0;
        for (int i = 0; i < 400 && fired == 0; i++) begin
            @(negedge clk);
            #2;
            play = 1'b1;
            if (beat && m_mode == M_BEATS && m_remain == 1 && m_ptr == 40) begin
                restart = 1'b1;
                fired   = 1;
            end else begin
                restart = 1'b0;
            end
        end
        checkOutput("t6_restart_fired", fired, 1);
        checkOutput("t6_strobes_before", strobe_cyc.size(), 41);
        n_before = strobe_cyc.size();
        saw41 = 0;
        for (int i = 0; i < 20 && strobe_cyc.size() <= n_before; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (rom_addr == 7'd41) saw41 = 1;
        end
        checkOutput("t6_no_addr41", saw41, 0);
        checkOutput("t6_rom_addr", int'(rom_addr), 0);
        checkOutput("t6_strobe_after", strobe_cyc.size(), n_before + 1);
        if (strobe_cyc.size() > n_before) begin
            checkOutput("t6_note", strobe_note[n_before], 1);
            checkOutput("t6_dur", strobe_dur[n_before], 1);
        end

        repeat (4) applyStimulus(1'b1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
